shift_seq: RTL and testbench

SHIFT_SEQ -- requirements
Module: shift_seq

---
 rtl/shift_seq_if.sv | 26 ++
 rtl/shift_seq.sv | 126 ++++++++++++
 tb/tb_shift_seq.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/shift_seq_if.sv
// Command and shifter-control bundle for shift_seq.
// Purely structural: no storage, no latency.
// Requester holds a command until req_ready; shifter-side signals have no backpressure.
interface shift_seq_if;
   logic       req_valid;
   logic [2:0] req_op;
   logic [7:0] req_data;
   logic [2:0] req_count;
   logic       req_ready;
   logic [2:0] shiftOp;
   logic [7:0] shiftIn;
   logic       serialIn;
   logic [7:0] shadow;
   logic       busy;
   logic       done;

   modport master (
      output req_valid, req_op, req_data, req_count,
      input  req_ready, shiftOp, shiftIn, serialIn, shadow, busy, done
   );

   modport slave (
      input  req_valid, req_op, req_data, req_count,
      output req_ready, shiftOp, shiftIn, serialIn, shadow, busy, done
   );
endinterface

// File: rtl/shift_seq.sv
// Sequences commands onto an 8-bit shift register that has no hold op, tracking its contents in shadow.
// Load/clear finish at the accept edge (done next cycle); shift ops take N RUN cycles (N=1..8).
// req_ready is low during RUN and reset; req_valid is ignored while a command runs.
module shift_seq (
   input logic        clk,
   input logic        rst,
   shift_seq_if.slave bus
);

   typedef enum logic {IDLE, RUN} state_t;

   state_t     state, state_nxt;
   logic [7:0] shadow_q, shadow_nxt;
   logic [2:0] op_q, op_nxt;
   logic [7:0] sdat_q, sdat_nxt;   // serial source, next bit to emit at bit 7
   logic [3:0] rem_q, rem_nxt;     // RUN cycles remaining, including the current one
   logic       done_q, done_nxt;
   logic [2:0] shift_op;
   logic [7:0] shift_in;
   logic       serial;
   logic       ready;
   logic       accept;
   logic [3:0] n_cnt;

   // A count of zero encodes a full 8-cycle command.
   assign n_cnt = (bus.req_count == 3'd0) ? 4'd8 : {1'b0, bus.req_count};

   // Next-state, datapath updates and the shifter drive for this cycle.
   always_comb begin
      state_nxt  = state;
      shadow_nxt = shadow_q;
      op_nxt     = op_q;
      sdat_nxt   = sdat_q;
      rem_nxt    = rem_q;
      done_nxt   = 1'b0;
      shift_op   = 3'b001;        // reload own contents: the register has no hold op
      shift_in   = shadow_q;
      serial     = 1'b0;
      ready      = (state == IDLE) && !rst;
      accept     = ready && bus.req_valid;

      if (rst) begin
         shift_op = 3'b000;
         shift_in = 8'h00;
      end else begin
         case (state)
            IDLE: begin
               if (accept) begin
                  case (bus.req_op)
                     3'b000: begin
                        shift_op   = 3'b000;
                        shift_in   = 8'h00;
                        shadow_nxt = 8'h00;
                        done_nxt   = 1'b1;
                     end
                     3'b001: begin
                        shift_in   = bus.req_data;
                        shadow_nxt = bus.req_data;
                        done_nxt   = 1'b1;
                     end
                     default: begin
                        // Left-justify the N serial bits so bit 7 is always the next one out.
                        op_nxt    = bus.req_op;
                        sdat_nxt  = bus.req_data << (4'd8 - n_cnt);
                        rem_nxt   = n_cnt;
                        state_nxt = RUN;
                     end
                  endcase
               end
            end
            RUN: begin
               shift_op = op_q;
               serial   = (op_q == 3'b101) && sdat_q[7];
               sdat_nxt = {sdat_q[6:0], 1'b0};
               rem_nxt  = rem_q - 4'd1;
               case (op_q)
                  3'b010:  shadow_nxt = {1'b0, shadow_q[7:1]};
                  3'b011:  shadow_nxt = {shadow_q[6:0], 1'b0};
                  3'b100:  shadow_nxt = {shadow_q[7], shadow_q[7:1]};
                  3'b101:  shadow_nxt = {shadow_q[6:0], serial};
                  3'b110:  shadow_nxt = {shadow_q[0], shadow_q[7:1]};
                  3'b111:  shadow_nxt = {shadow_q[6:0], shadow_q[7]};
                  default: shadow_nxt = shadow_q;
               endcase
               if (rem_q == 4'd1) begin
                  state_nxt = IDLE;
                  done_nxt  = 1'b1;
               end
            end
            default: state_nxt = IDLE;
         endcase
      end
   end

   // FSM state register; reset aborts any running command.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Datapath registers; shadow clears with the shift register on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         shadow_q <= 8'h00;
         op_q     <= 3'b000;
         sdat_q   <= 8'h00;
         rem_q    <= 4'd0;
         done_q   <= 1'b0;
      end else begin
         shadow_q <= shadow_nxt;
         op_q     <= op_nxt;
         sdat_q   <= sdat_nxt;
         rem_q    <= rem_nxt;
         done_q   <= done_nxt;
      end
   end

   assign bus.req_ready = ready;
   assign bus.shiftOp   = shift_op;
   assign bus.shiftIn   = shift_in;
   assign bus.serialIn  = serial;
   assign bus.shadow    = shadow_q;
   assign bus.busy      = (state == RUN) && !rst;
   assign bus.done      = done_q && !rst;

endmodule

// File: tb/tb_shift_seq.sv
// Self-checking bench for shift_seq: directed scenarios then randomized commands.
// Expected shadow values come from closed-form shift/rotate arithmetic on the command as a whole.
module tb_shift_seq;

   logic clk = 1'b0;
   logic rst;
   int   passed = 0;
   int   failed = 0;
   int   total  = 0;
   logic [7:0] m_shadow;

   shift_seq_if bus();

   shift_seq dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   // Shift register contents after j of the N steps of a command starting from s.
   function automatic logic [7:0] model(input logic [2:0] op, input logic [7:0] s,
                                        input logic [7:0] d, input int n, input int j);
      int si, di, v;
      si = int'(s);
      di = int'(d);
      case (op)
         3'd2:    v = si >> j;
         3'd3:    v = si << j;
         3'd4:    v = (si >> j) | (s[7] ? (255 << (8 - j)) : 0);
         3'd5:    v = (si << j) | ((di & ((1 << n) - 1)) >> (n - j));
         3'd6:    v = (si >> j) | (si << (8 - j));
         3'd7:    v = (si << j) | (si >> (8 - j));
         default: v = si;
      endcase
      return 8'(v);
   endfunction

   task automatic idle(input int cycles);
      bus.req_valid = 1'b0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         check("idle_done",   8'(bus.done),      8'd0);
         check("idle_busy",   8'(bus.busy),      8'd0);
         check("idle_ready",  8'(bus.req_ready), 8'd1);
         check("idle_op",     8'(bus.shiftOp),   8'd1);
         check("idle_in",     bus.shiftIn,       m_shadow);
         check("idle_ser",    8'(bus.serialIn),  8'd0);
         check("idle_shadow", bus.shadow,        m_shadow);
      end
   endtask

   // Issue one command; rst_at >= 0 asserts reset during that RUN cycle.
   task automatic do_cmd(input logic [2:0] op, input logic [7:0] d,
                         input logic [2:0] cnt, input int rst_at);
      int n;
      logic [7:0] s0;
      n  = (cnt == 3'd0) ? 8 : int'(cnt);
      s0 = m_shadow;
      check("req_ready", 8'(bus.req_ready), 8'd1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_data  = d;
      bus.req_count = cnt;
      #1;
      check("acc_op",   8'(bus.shiftOp),  (op == 3'd0) ? 8'd0 : 8'd1);
      check("acc_in",   bus.shiftIn,      (op == 3'd0) ? 8'd0 : ((op == 3'd1) ? d : s0));
      check("acc_ser",  8'(bus.serialIn), 8'd0);
      check("acc_busy", 8'(bus.busy),     8'd0);
      tick();
      if (op <= 3'd1) begin
         bus.req_valid = 1'b0;
         m_shadow = (op == 3'd0) ? 8'h00 : d;
         check("ld_done",   8'(bus.done),      8'd1);
         check("ld_ready",  8'(bus.req_ready), 8'd1);
         check("ld_shadow", bus.shadow,        m_shadow);
         return;
      end
      for (int k = 0; k < n; k++) begin
         // Junk requests during RUN must be ignored.
         bus.req_valid = (k == n - 1) ? 1'b0 : 1'($urandom);
         bus.req_op    = 3'($urandom);
         bus.req_data  = 8'($urandom);
         bus.req_count = 3'($urandom);
         #1;
         check("run_busy",  8'(bus.busy),      8'd1);
         check("run_ready", 8'(bus.req_ready), 8'd0);
         check("run_done",  8'(bus.done),      8'd0);
         check("run_op",    8'(bus.shiftOp),   8'(op));
         check("run_in",    bus.shiftIn,       model(op, s0, d, n, k));
         check("run_ser",   8'(bus.serialIn),  (op == 3'd5) ? 8'(d[n - 1 - k]) : 8'd0);
         if (k == rst_at) begin
            rst = 1'b1;
            #1;
            check("rst_op",    8'(bus.shiftOp),   8'd0);
            check("rst_in",    bus.shiftIn,       8'd0);
            check("rst_busy",  8'(bus.busy),      8'd0);
            check("rst_ready", 8'(bus.req_ready), 8'd0);
            tick();
            rst = 1'b0;
            m_shadow = 8'h00;
            #1;
            check("abort_ready",  8'(bus.req_ready), 8'd1);
            check("abort_done",   8'(bus.done),      8'd0);
            check("abort_busy",   8'(bus.busy),      8'd0);
            check("abort_shadow", bus.shadow,        8'h00);
            return;
         end
         tick();
         check("run_shadow", bus.shadow, model(op, s0, d, n, k + 1));
      end
      m_shadow = model(op, s0, d, n, n);
      check("sh_done",  8'(bus.done),      8'd1);
      check("sh_busy",  8'(bus.busy),      8'd0);
      check("sh_ready", 8'(bus.req_ready), 8'd1);
   endtask

   initial begin
      int op, n, ra;
      rst           = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_op    = 3'd0;
      bus.req_data  = 8'h00;
      bus.req_count = 3'd0;
      m_shadow      = 8'h00;
      #2;
      check("rst_op0",    8'(bus.shiftOp),   8'd0);
      check("rst_in0",    bus.shiftIn,       8'd0);
      check("rst_ser0",   8'(bus.serialIn),  8'd0);
      check("rst_ready0", 8'(bus.req_ready), 8'd0);
      check("rst_busy0",  8'(bus.busy),      8'd0);
      check("rst_done0",  8'(bus.done),      8'd0);
      tick();
      rst = 1'b0;
      #1;
      check("post_rst_shadow", bus.shadow,        8'h00);
      check("post_rst_ready",  8'(bus.req_ready), 8'd1);
      check("post_rst_done",   8'(bus.done),      8'd0);

      // Load then five idle cycles holding the value.
      do_cmd(3'd1, 8'hA5, 3'd0, -1);
      idle(5);
      check("hold_a5", bus.shadow, 8'hA5);

      // Arithmetic right by 3.
      do_cmd(3'd1, 8'h96, 3'd0, -1);
      do_cmd(3'd4, 8'h00, 3'd3, -1);
      check("asr_f2", bus.shadow, 8'hF2);
      idle(1);

      // Eight-cycle rotate left leaves the value unchanged.
      do_cmd(3'd1, 8'h3C, 3'd0, -1);
      do_cmd(3'd7, 8'h00, 3'd0, -1);
      check("rol8_3c", bus.shadow, 8'h3C);
      idle(1);

      // Serial in of a full byte.
      do_cmd(3'd5, 8'hD2, 3'd0, -1);
      check("ser_d2", bus.shadow, 8'hD2);
      idle(1);

      // Back-to-back commands issued in each done cycle.
      do_cmd(3'd1, 8'h81, 3'd0, -1);
      do_cmd(3'd3, 8'h00, 3'd2, -1);
      check("shl_04", bus.shadow, 8'h04);
      do_cmd(3'd2, 8'h00, 3'd1, -1);
      check("shr_02", bus.shadow, 8'h02);
      idle(1);

      // Reset on the second RUN cycle of a rotate right.
      do_cmd(3'd1, 8'hFF, 3'd0, -1);
      do_cmd(3'd6, 8'h00, 3'd5, 1);
      idle(1);

      // Randomized commands, occasional idle gaps and reset aborts.
      for (int i = 0; i < 60; i++) begin
         logic [2:0] cnt;
         op  = int'($urandom_range(0, 7));
         cnt = 3'($urandom);
         n   = (cnt == 3'd0) ? 8 : int'(cnt);
         ra  = (op >= 2 && $urandom_range(0, 7) == 0) ? int'($urandom_range(0, n - 1)) : -1;
         do_cmd(3'(op), 8'($urandom), cnt, ra);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end
      idle(2);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
